timer_counter: RTL and testbench

//  Memory-mapped timer/counter peripheral on the bus behind the CPU's BrAddr/BrWData/BrWE/BrRData bridge port.

---
 rtl/timer_counter.sv | 137 +++++++++++++
 tb/tb_timer_counter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped down-counter with one-shot / auto-reload modes and an IRQ at zero.
// Optional feature macro TC_PRESCALER_EN adds the PSC register at 0xC and a count prescaler.
module timer_counter #(
  parameter logic [31:0] PRESET_RST = 32'h0,
  parameter logic [1:0]  MODE_RST   = 2'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic [3:0]  we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      r_state;
  logic        r_en;
  logic        r_im;
  logic [1:0]  r_mode;
  logic        r_irqFlag;
  logic [31:0] r_preset;
  logic [31:0] r_count;

  logic        w_wrCtrl;
  logic [3:0]  w_presetLanes;
  logic        w_nextEn;
  logic        w_tick;

  assign w_wrCtrl      = sel && (addr == 2'd0) && we[0];
  assign w_presetLanes = (sel && (addr == 2'd1)) ? we : 4'b0000;
  assign w_nextEn      = w_wrCtrl ? wdata[0] : r_en;

`ifdef TC_PRESCALER_EN
  logic [15:0] r_psc;
  logic [15:0] r_pscCnt;
  logic [1:0]  w_pscLanes;

  assign w_pscLanes = (sel && (addr == 2'd3)) ? we[1:0] : 2'b00;
  assign w_tick     = (r_pscCnt == r_psc);

  // The prescale counter only advances while actively counting; LOAD restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_psc    <= 16'h0;
      r_pscCnt <= 16'h0;
    end else begin
      if (r_state == LOAD)
        r_pscCnt <= 16'h0;
      else if (r_state == CNT && r_en)
        r_pscCnt <= w_tick ? 16'h0 : r_pscCnt + 16'd1;
      if (w_pscLanes[0]) r_psc[7:0]  <= wdata[7:0];
      if (w_pscLanes[1]) r_psc[15:8] <= wdata[15:8];
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  // Bus writes come after the FSM so a CPU write to CTRL overrides any internal update.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_en      <= 1'b0;
      r_im      <= 1'b0;
      r_mode    <= MODE_RST;
      r_irqFlag <= 1'b0;
      r_preset  <= PRESET_RST;
      r_count   <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_en) r_state <= LOAD;
        end
        LOAD: begin
          r_count <= r_preset;
          r_state <= CNT;
        end
        CNT: begin
          if (!r_en) begin
            r_state <= IDLE;
          end else if (w_tick) begin
            if (r_count > 32'd1) begin
              r_count <= r_count - 32'd1;
            end else begin
              r_count   <= 32'h0;
              r_irqFlag <= 1'b1;
              r_state   <= INT;
            end
          end
        end
        INT: begin
          // Auto-reload jumps straight to LOAD so the period is PRESET+2 cycles.
          if (r_mode == 2'd1) begin
            r_irqFlag <= 1'b0;
            r_state   <= w_nextEn ? LOAD : IDLE;
          end else begin
            r_en    <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_wrCtrl) begin
        r_en      <= wdata[0];
        r_mode    <= wdata[2:1];
        r_im      <= wdata[3];
        r_irqFlag <= 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        if (w_presetLanes[i]) r_preset[8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (sel) begin
      case (addr)
        2'd0:    rdata = {28'h0, r_im, r_mode, r_en};
        2'd1:    rdata = r_preset;
        2'd2:    rdata = r_count;
`ifdef TC_PRESCALER_EN
        default: rdata = {16'h0, r_psc};
`else
        default: rdata = 32'h0;
`endif
      endcase
    end
  end

  assign irq = r_irqFlag & r_im;

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed timing scenarios plus random bus traffic, all checked against
// a behavioural model of the timer kept in the bench.
module tb_timer_counter;

   localparam logic [31:0] PRESET_RST = 32'h0000_0005;
   localparam logic [1:0]  MODE_RST   = 2'd0;

   logic        clk;
   logic        reset;
   logic        sel;
   logic [1:0]  addr;
   logic [3:0]  we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   int checks = 0;
   int errors = 0;
   int pulses;
   logic lastIrq;

   // Model state: programmed registers plus the counting timeline expressed as flags.
   logic        mEn, mIm, mFlag;
   logic [1:0]  mMode;
   logic [31:0] mPreset, mCount;
   logic [15:0] mPsc;
   int          mPhase;
   bit          mCounting, mLoadNext, mFired;

   timer_counter #(.PRESET_RST(PRESET_RST), .MODE_RST(MODE_RST)) dut (
      .clk(clk), .reset(reset), .sel(sel), .addr(addr), .we(we),
      .wdata(wdata), .rdata(rdata), .irq(irq)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point for every check in the bench.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] modelRead(input logic [1:0] a);
      case (a)
         2'd0: return {28'h0, mIm, mMode, mEn};
         2'd1: return mPreset;
         2'd2: return mCount;
`ifdef TC_PRESCALER_EN
         default: return {16'h0, mPsc};
`else
         default: return 32'h0;
`endif
      endcase
   endfunction

   // Advance the model across one clock edge given the bus inputs present at that edge.
   function automatic void modelEdge(input logic rst, input logic s, input logic [1:0] a,
                                     input logic [3:0] w, input logic [31:0] d);
      bit wrCtrl;
      if (rst) begin
         mEn = 0; mIm = 0; mFlag = 0; mMode = MODE_RST;
         mPreset = PRESET_RST; mCount = 0; mPsc = 0; mPhase = 0;
         mCounting = 0; mLoadNext = 0; mFired = 0;
         return;
      end
      wrCtrl = s && (a == 2'd0) && w[0];
      if (mFired) begin
         mFired = 0;
         if (mMode == 2'd1) begin
            mFlag = 0;
            mLoadNext = wrCtrl ? d[0] : mEn;
         end else begin
            mEn = 0;
         end
      end else if (mLoadNext) begin
         mLoadNext = 0;
         mCount = mPreset;
         mPhase = 0;
         mCounting = 1;
      end else if (mCounting) begin
         if (!mEn) begin
            mCounting = 0;
         end else if (mPhase == int'(mPsc)) begin
            mPhase = 0;
            if (mCount <= 1) begin
               mCount = 0; mFlag = 1; mFired = 1; mCounting = 0;
            end else begin
               mCount = mCount - 1;
            end
         end else begin
            mPhase++;
         end
      end else if (mEn) begin
         mLoadNext = 1;
      end
      if (wrCtrl) begin
         mEn = d[0]; mMode = d[2:1]; mIm = d[3]; mFlag = 0;
      end
      if (s && a == 2'd1)
         for (int i = 0; i < 4; i++) if (w[i]) mPreset[8*i +: 8] = d[8*i +: 8];
`ifdef TC_PRESCALER_EN
      if (s && a == 2'd3) begin
         if (w[0]) mPsc[7:0]  = d[7:0];
         if (w[1]) mPsc[15:8] = d[15:8];
      end
`endif
   endfunction

   // One bus cycle: drive on the falling edge, compare against the model, then clock both.
   task automatic applyStimulus(input logic rst, input logic s, input logic [1:0] a,
                                input logic [3:0] w, input logic [31:0] d, input string tag);
      @(negedge clk);
      reset = rst; sel = s; addr = a; we = w; wdata = d;
      #1;
      lastIrq = irq;
      if (!rst) begin
         checkOutput({tag, ":rdata"}, rdata, s ? modelRead(a) : 32'h0);
         checkOutput({tag, ":irq"}, {31'h0, irq}, {31'h0, mFlag & mIm});
      end
      @(posedge clk);
      modelEdge(rst, s, a, w, d);
   endtask

   // Read with a hand-derived expectation in addition to the model comparison.
   task automatic spotRead(input string tag, input logic [1:0] a, input logic [31:0] exp, input logic expIrq);
      @(negedge clk);
      reset = 0; sel = 1; addr = a; we = 4'h0; wdata = 32'h0;
      #1;
      checkOutput(tag, rdata, exp);
      checkOutput({tag, "_irq"}, {31'h0, irq}, {31'h0, expIrq});
      @(posedge clk);
      modelEdge(0, 1, a, 4'h0, 32'h0);
   endtask

   task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
      applyStimulus(0, 1, a, 4'hF, d, "wr");
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(0, 1, 2'd2, 4'h0, 32'h0, "cnt");
         if (lastIrq === 1'b1) pulses++;
      end
   endtask

   initial begin
      reset = 1; sel = 0; addr = 0; we = 0; wdata = 0; lastIrq = 0; pulses = 0;
      applyStimulus(1, 0, 2'd0, 4'h0, 32'h0, "rst");
      applyStimulus(1, 0, 2'd0, 4'h0, 32'h0, "rst");

      // Reset values.
      spotRead("t1_ctrl", 2'd0, 32'h0, 1'b0);
      spotRead("t1_preset", 2'd1, PRESET_RST, 1'b0);
      spotRead("t1_count", 2'd2, 32'h0, 1'b0);
      applyStimulus(0, 0, 2'd1, 4'h0, 32'h0, "t1_nosel");

      // One-shot countdown from 5 with exact edge timing.
      writeReg(2'd1, 32'd5);
      writeReg(2'd0, 32'h9);
      spotRead("t2_pre0", 2'd2, 32'd0, 1'b0);
      spotRead("t2_pre1", 2'd2, 32'd0, 1'b0);
      for (int k = 5; k >= 1; k--) spotRead("t2_count", 2'd2, 32'(k), 1'b0);
      spotRead("t2_zero", 2'd2, 32'd0, 1'b1);
      spotRead("t2_ctrl", 2'd0, 32'h8, 1'b1);
      idle(3);
      spotRead("t2_hold", 2'd0, 32'h8, 1'b1);
      writeReg(2'd0, 32'h8);
      spotRead("t2_clear", 2'd0, 32'h8, 1'b0);

      // Auto-reload with PRESET=3: one-cycle pulse every 5 cycles, then stop mid-count.
      writeReg(2'd1, 32'd3);
      writeReg(2'd0, 32'hB);
      pulses = 0;
      idle(16);
      checkOutput("t3_pulses", 32'(pulses), 32'd3);
      idle(2);
      writeReg(2'd0, 32'h8);
      pulses = 0;
      idle(10);
      checkOutput("t3_nopulse", 32'(pulses), 32'd0);
      spotRead("t3_frozen", 2'd2, 32'd1, 1'b0);

      // PRESET rewritten mid-count applies only at the next reload.
      writeReg(2'd1, 32'd10);
      writeReg(2'd0, 32'hB);
      idle(5);
      writeReg(2'd1, 32'd2);
      spotRead("t4_cont", 2'd2, 32'd6, 1'b0);
      idle(4);
      spotRead("t4_one", 2'd2, 32'd1, 1'b0);
      spotRead("t4_zero", 2'd2, 32'd0, 1'b1);
      spotRead("t4_load", 2'd2, 32'd0, 1'b0);
      spotRead("t4_reload", 2'd2, 32'd2, 1'b0);
      writeReg(2'd0, 32'h0);
      idle(2);

      // IM=0 masks the request; a CTRL write then clears the hidden flag.
      writeReg(2'd1, 32'd1);
      writeReg(2'd0, 32'h1);
      idle(6);
      spotRead("t5_masked", 2'd2, 32'd0, 1'b0);
      writeReg(2'd0, 32'h8);
      spotRead("t5_cleared", 2'd0, 32'h8, 1'b0);

      // PRESET=0 behaves like PRESET=1.
      writeReg(2'd1, 32'd0);
      writeReg(2'd0, 32'h9);
      for (int k = 0; k < 3; k++) spotRead("t5_p0", 2'd2, 32'd0, 1'b0);
      spotRead("t5_p0irq", 2'd2, 32'd0, 1'b1);
      writeReg(2'd0, 32'h0);
      idle(2);

      // CTRL write on the terminal edge clears the flag being set.
      writeReg(2'd1, 32'd2);
      writeReg(2'd0, 32'h9);
      idle(3);
      writeReg(2'd0, 32'h9);
      spotRead("t6_clrwins", 2'd2, 32'd0, 1'b0);
      writeReg(2'd0, 32'h0);
      idle(2);

      // CTRL write in INT keeps En set, so the counter reloads.
      writeReg(2'd0, 32'h9);
      idle(4);
      writeReg(2'd0, 32'h9);
      spotRead("t7_ctrl", 2'd0, 32'h9, 1'b0);
      idle(1);
      spotRead("t7_reload", 2'd2, 32'd2, 1'b0);
      writeReg(2'd0, 32'h0);
      idle(2);

`ifdef TC_PRESCALER_EN
      // Prescaled countdown: PSC=2 stretches each count step to three cycles.
      writeReg(2'd3, 32'd2);
      writeReg(2'd1, 32'd2);
      writeReg(2'd0, 32'h9);
      idle(2);
      spotRead("t8_c2", 2'd2, 32'd2, 1'b0);
      idle(2);
      spotRead("t8_c1", 2'd2, 32'd1, 1'b0);
      idle(2);
      spotRead("t8_c0", 2'd2, 32'd0, 1'b1);
      writeReg(2'd0, 32'h0);
      idle(2);
`endif

      // Reset in the middle of a count returns everything to reset values.
      writeReg(2'd3, 32'd1);
      writeReg(2'd1, 32'd4);
      writeReg(2'd0, 32'hB);
      idle(3);
      applyStimulus(1, 0, 2'd0, 4'h0, 32'h0, "rst");
      spotRead("t9_ctrl", 2'd0, 32'h0, 1'b0);
      spotRead("t9_preset", 2'd1, PRESET_RST, 1'b0);
      spotRead("t9_count", 2'd2, 32'h0, 1'b0);
      spotRead("t9_psc", 2'd3, 32'h0, 1'b0);

      // Random bus traffic checked cycle by cycle against the model.
      for (int n = 0; n < 1500; n++) begin
         int r;
         logic [1:0] a;
         logic [31:0] d;
         r = $urandom_range(0, 127);
         a = 2'($urandom_range(0, 3));
         if (r == 0) begin
            applyStimulus(1, 0, 2'd0, 4'h0, 32'h0, "rnd_rst");
         end else if (r < 20) begin
            case (a)
               2'd0:    d = $urandom;
               2'd1:    d = 32'($urandom_range(0, 6));
               2'd3:    d = 32'($urandom_range(0, 3));
               default: d = $urandom;
            endcase
            applyStimulus(0, ($urandom_range(0, 7) != 0), a, 4'($urandom_range(0, 15)), d, "rnd_wr");
         end else begin
            applyStimulus(0, ($urandom_range(0, 7) != 0), a, 4'h0, $urandom, "rnd_rd");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
